// File: rtl/unidade_controle_jogadas_if.sv
// Handshake bundle between the game control unit and its datapath/edge-detector side.
// The master side drives the move strobes; the slave side is the control unit.
interface unidade_controle_jogadas_if #(
  parameter int ADDR_W = 4
);
  logic              iniciar;
  logic              jogada;
  logic              igual;
  logic              zeraR;
  logic              registraR;
  logic [ADDR_W-1:0] endereco;
  logic              pronto;
  logic              acertou;
  logic              errou;
  logic              timeout;
  logic [3:0]        db_estado;

  modport master (
    output iniciar, jogada, igual,
    input  zeraR, registraR, endereco, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, igual,
    output zeraR, registraR, endereco, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogadas.sv
// Control unit for the memory-sequence game: walks the ROM address over one round,
// times out idle moves and latches the round outcome until the next start request.
module unidade_controle_jogadas #(
  parameter int ADDR_W         = 4,
  parameter int N_JOGADAS      = 16,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int STOP_ON_ERROR  = 1
) (
  input logic                  clock,
  input logic                  reset,
  unidade_controle_jogadas_if.slave bus
);

  // State encoding doubles as the debug display code.
  typedef enum logic [3:0] {
    inicial     = 4'h0,
    preparacao  = 4'h1,
    espera      = 4'h2,
    registra    = 4'h4,
    comparacao  = 4'h5,
    proximo     = 4'h6,
    fim_acerto  = 4'hA,
    fim_erro    = 4'hE,
    fim_timeout = 4'hD
  } estado_t;

  typedef struct packed {
    logic       zera_r;
    logic       registra_r;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db;
  } saidas_t;

  localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TMO_LIM  = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ULTIMO   = ADDR_W'(N_JOGADAS - 1);

  estado_t           estado;
  estado_t           proximo_estado;
  saidas_t           saidas;
  logic [ADDR_W-1:0] endereco;
  logic [TCNT_W-1:0] tcnt;
  logic              erro_flag;
  logic              tmo;
  logic              ultima;

  function automatic saidas_t decode(input estado_t s);
    saidas_t o;
    o = '0;
    o.db = s;
    case (s)
      inicial, preparacao: o.zera_r     = 1'b1;
      registra:            o.registra_r = 1'b1;
      fim_acerto:  begin o.pronto = 1'b1; o.acertou = 1'b1; end
      fim_erro:    begin o.pronto = 1'b1; o.errou   = 1'b1; end
      fim_timeout: begin o.pronto = 1'b1; o.timeout = 1'b1; end
      espera, comparacao, proximo: ;
      default: o.db = 4'hF;
    endcase
    return o;
  endfunction

  assign tmo    = (TIMEOUT_CYCLES != 0) && (tcnt == TMO_LIM);
  assign ultima = (endereco == ULTIMO);

  always_comb begin
    // NOTE: default assignment first so no path leaves proximo_estado unassigned (no latch).
    proximo_estado = inicial;
    case (estado)
      inicial:    proximo_estado = bus.iniciar ? preparacao : inicial;
      preparacao: proximo_estado = espera;
      espera: begin
        if (bus.jogada)   proximo_estado = registra;
        else if (tmo)     proximo_estado = fim_timeout;
        else              proximo_estado = espera;
      end
      registra:   proximo_estado = comparacao;
      comparacao: begin
        if (!bus.igual && (STOP_ON_ERROR != 0)) proximo_estado = fim_erro;
        else if (ultima) proximo_estado = (erro_flag || !bus.igual) ? fim_erro : fim_acerto;
        else             proximo_estado = proximo;
      end
      proximo:    proximo_estado = espera;
      fim_acerto, fim_erro, fim_timeout:
        proximo_estado = bus.iniciar ? preparacao : estado;
      default:    proximo_estado = inicial;
    endcase
  end

  // Outputs are registered from the next state so they change exactly with the state.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments; reset is asynchronous and covers
    // every register, including the latched outcome.
    if (reset) begin
      estado    <= inicial;
      saidas    <= decode(inicial);
      endereco  <= '0;
      tcnt      <= '0;
      erro_flag <= 1'b0;
    end else begin
      estado <= proximo_estado;
      saidas <= decode(proximo_estado);
      case (estado)
        preparacao: begin
          endereco  <= '0;
          erro_flag <= 1'b0;
          tcnt      <= '0;
        end
        espera: begin
          if (tcnt != TCNT_MAX) tcnt <= tcnt + TCNT_W'(1);
        end
        comparacao: begin
          if (proximo_estado == proximo) erro_flag <= erro_flag | ~bus.igual;
        end
        proximo: begin
          if (!ultima) endereco <= endereco + ADDR_W'(1);
          tcnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.zeraR     = saidas.zera_r;
  assign bus.registraR = saidas.registra_r;
  assign bus.pronto    = saidas.pronto;
  assign bus.acertou   = saidas.acertou;
  assign bus.errou     = saidas.errou;
  assign bus.timeout   = saidas.timeout;
  assign bus.db_estado = saidas.db;
  assign bus.endereco  = endereco;

endmodule
